// File: rtl/rz_stream_pkg.sv
// Shared helpers for valid/hold stream stages.
package rz_stream_pkg;

   // A beat moves on any edge where valid is high and hold is low.
   function automatic logic xfer(input logic valid, input logic hold);
      return valid & ~hold;
   endfunction

endpackage

// File: rtl/hold_skid.sv
// Backpressure pipeline stage: registered upstream hold with a one-beat skid register
// so that q_hold never reaches di_hold combinationally.
module hold_skid
   import rz_stream_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          di_valid,
   input  logic [DW-1:0] di,
   output logic          di_hold,
   output logic          q_valid,
   output logic [DW-1:0] q,
   input  logic          q_hold
);

   logic          q_valid_q, q_valid_d;
   logic [DW-1:0] q_q, q_d;
   logic          s_valid_q, s_valid_d;
   logic [DW-1:0] s_q, s_d;
   logic          accept;
   logic          main_free;

   assign accept    = xfer(di_valid, s_valid_q);
   assign main_free = ~q_valid_q | ~q_hold;

   always_comb begin
      q_valid_d = q_valid_q;
      q_d       = q_q;
      s_valid_d = s_valid_q;
      s_d       = s_q;
      if (main_free) begin
         if (s_valid_q) begin
            // Skid beat is older than anything upstream; it goes first.
            q_d       = s_q;
            q_valid_d = 1'b1;
            s_valid_d = 1'b0;
         end else begin
            q_valid_d = accept;
            if (accept) begin
               q_d = di;
            end
         end
      end else if (accept) begin
         s_d       = di;
         s_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
      end else begin
         q_valid_q <= q_valid_d;
         s_valid_q <= s_valid_d;
      end
   end

   // Data registers carry no reset; their contents are ignored while invalid.
   always_ff @(posedge clk) begin
      q_q <= q_d;
      s_q <= s_d;
   end

   assign di_hold = s_valid_q;
   assign q_valid = q_valid_q;
   assign q       = q_q;

endmodule

// File: tb/tb_hold_skid.sv
// Directed and scoreboarded checks for the hold_skid stream stage.
module tb_hold_skid;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          di_valid;
   logic [DW-1:0] di;
   logic          di_hold;
   logic          q_valid;
   logic [DW-1:0] q;
   logic          q_hold;

   int            vectors = 0;
   int            errors  = 0;
   logic [15:0]   next_in;
   logic [15:0]   exp_out;
   int            drained;

   hold_skid #(.DW(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .di_valid (di_valid),
      .di       (di),
      .di_hold  (di_hold),
      .q_valid  (q_valid),
      .q        (q),
      .q_hold   (q_hold)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle with order/occupancy scoreboard; di carries the next sequence number.
   task automatic sb_cycle();
      logic          drn, acc, stall;
      logic [DW-1:0] q_prev;
      int            held;
      di     = next_in[DW-1:0];
      drn    = q_valid & ~q_hold;
      acc    = di_valid & ~di_hold;
      stall  = q_valid & q_hold;
      q_prev = q;
      if (drn) begin
         chk("order", {24'd0, q}, {24'd0, exp_out[DW-1:0]});
         exp_out++;
         drained++;
      end
      if (acc) next_in++;
      tick();
      if (stall) begin
         chk("hold_q", {24'd0, q}, {24'd0, q_prev});
         chk("hold_qv", {31'd0, q_valid}, 32'd1);
      end
      held = int'(next_in) - int'(exp_out);
      chk("qv_occ", {31'd0, q_valid}, {31'd0, held != 0});
      chk("dh_occ", {31'd0, di_hold}, {31'd0, held == 2});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      di_valid = 1'b0;
      q_hold = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; di_valid = 1'b0; di = '0; q_hold = 1'b0;
      next_in = '0; exp_out = '0; drained = 0;
      tick();
      tick();
      chk("rst_qv", {31'd0, q_valid}, 32'd0);
      chk("rst_dh", {31'd0, di_hold}, 32'd0);
      reset = 1'b0;

      // T1 streaming
      q_hold = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         di_valid = 1'b1;
         di = 8'(i);
         tick();
         chk("t1_qv", {31'd0, q_valid}, 32'd1);
         chk("t1_q", {24'd0, q}, i);
         chk("t1_dh", {31'd0, di_hold}, 32'd0);
      end
      di_valid = 1'b0;
      tick();
      chk("t1_idle", {31'd0, q_valid}, 32'd0);

      // T2 skid capture
      di_valid = 1'b1; di = 8'hA0;
      tick();
      chk("t2_load", {24'd0, q}, 32'hA0);
      q_hold = 1'b1; di = 8'hA1;
      tick();
      chk("t2_dh", {31'd0, di_hold}, 32'd1);
      chk("t2_q", {24'd0, q}, 32'hA0);
      di_valid = 1'b0;
      tick();
      chk("t2_q_held", {24'd0, q}, 32'hA0);
      chk("t2_dh_held", {31'd0, di_hold}, 32'd1);
      q_hold = 1'b0;
      tick();
      chk("t2_q2", {24'd0, q}, 32'hA1);
      chk("t2_qv2", {31'd0, q_valid}, 32'd1);
      chk("t2_dh_low", {31'd0, di_hold}, 32'd0);
      tick();
      chk("t2_empty", {31'd0, q_valid}, 32'd0);

      // T3 bubble collapse
      q_hold = 1'b1; di_valid = 1'b1; di = 8'h55;
      chk("t3_dh_pre", {31'd0, di_hold}, 32'd0);
      tick();
      chk("t3_qv", {31'd0, q_valid}, 32'd1);
      chk("t3_q", {24'd0, q}, 32'h55);
      chk("t3_dh", {31'd0, di_hold}, 32'd0);

      // T4 reset mid-operation
      di = 8'h66;
      tick();
      chk("t4_full", {31'd0, di_hold}, 32'd1);
      di_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t4_qv", {31'd0, q_valid}, 32'd0);
      chk("t4_dh", {31'd0, di_hold}, 32'd0);
      q_hold = 1'b0; di_valid = 1'b1; di = 8'h77;
      tick();
      chk("t4_q", {24'd0, q}, 32'h77);
      chk("t4_qv2", {31'd0, q_valid}, 32'd1);
      di_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_no_old", {31'd0, q_valid}, 32'd0);
      end

      // T6 hold toggling each cycle with continuous input
      do_reset();
      next_in = '0; exp_out = '0; drained = 0;
      di_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         q_hold = i[0];
         sb_cycle();
      end
      chk("t6_rate", {31'd0, drained >= 19}, 32'd1);

      // T5 randomized valid/hold
      do_reset();
      next_in = '0; exp_out = '0; drained = 0;
      for (int i = 0; i < 4000; i++) begin
         di_valid = 1'($urandom_range(0, 1));
         q_hold   = 1'($urandom_range(0, 1));
         sb_cycle();
      end
      di_valid = 1'b0; q_hold = 1'b0;
      for (int i = 0; i < 4; i++) sb_cycle();
      chk("t5_lossless", {16'd0, exp_out}, {16'd0, next_in});
      chk("t5_traffic", {31'd0, drained > 1000}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
